multi_port_ram: RTL and testbench
=================================

# multi_port_ram

Parametrised successor to the team's 8x256 distributed RAM: one synchronous write port and `N_RD` read ports, each either asynchronous or registered. Adds three things:
- a built-in clear sequencer that initialises every word after reset and on request;
- out-of-range protection for non-power-of-two depths;
- a sticky write-error flag.

It sits wherever the design needs small LUT-based lookup or scratch storage with a known power-up state.

## Interface
Parameters:
- `DATA_W`, 8, word width in bits (≥1).
- `ADDR_W`, 8, address width in bits (≥1).
- `DEPTH`, 256, number of words; 2 ≤ `DEPTH` ≤ 2^`ADDR_W`.
- `N_RD`, 2, number of read ports (≥1).
- `RD_REG`, 0. 0 = asynchronous read; 1 = registered read, write-first.
- `CLR_VAL`, 0, `DATA_W`-bit value written by the clear sequencer.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  write request for the current cycle.
- `wr_addr`  in  `ADDR_W`  write address.
- `wr_data`  in  `DATA_W`  write data.
- `clr_req`  in  1  request a full clear (single-cycle pulse or level).
- `rd_addr`  in  `N_RD*ADDR_W`  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- `rd_data`  out  `N_RD*DATA_W`  read data; port k uses bits [k*DATA_W +: DATA_W].
- `wr_ack`  out  1  combinational; high when this cycle's write is committed.
- `busy`  out  1  registered; high while the clear sequencer owns the array.
- `wr_err`  out  1  registered, sticky; a write was rejected.

## Operation
- Storage is a `DEPTH` x `DATA_W` array with no reset on the array itself.
- Two-state FSM, `CLEAR` and `IDLE`, with an `ADDR_W`-bit counter `clr_cnt`.

Reset and clear sequencer:
- Reset (`rst_n`=0 at an edge) sets state=`CLEAR`, `clr_cnt`=0, `busy`=1, `wr_err`=0, and registered `rd_data`=`CLR_VAL`.
- In `CLEAR`, each edge with `rst_n`=1 writes `CLR_VAL` to mem[`clr_cnt`] and increments `clr_cnt`.
- The edge that writes address `DEPTH`-1 moves the FSM to `IDLE` and clears `busy`.
- In `IDLE`, `clr_req`=1 at an edge moves to `CLEAR` with `clr_cnt`=0 and sets `busy`, and also clears `wr_err`.
- `clr_req` is ignored while in `CLEAR`; a clear is never restarted except by reset.

Writes:
- `wr_ack` = `wr_en` & !`busy` & (`wr_addr` < `DEPTH`).
- On `wr_ack`, mem[`wr_addr`] <= `wr_data` at the edge.
- An edge with `wr_en`=1 and `wr_ack`=0 (busy or out of range) sets `wr_err`. The array is not modified.
- `wr_en` and `clr_req` in the same `IDLE` cycle: the write commits, then clear starts next cycle and overwrites it. `wr_err` ends at 0.

Reads (per port k):
- Raw value = mem[`rd_addr`k] if `rd_addr`k < `DEPTH`, else `CLR_VAL`.
- While `busy`=1, the raw value is forced to `CLR_VAL`.
- `RD_REG`=0: `rd_data`k = raw value, combinationally.
- `RD_REG`=1: `rd_data`k registers the raw value at each edge. Write-first bypass: if `wr_ack` and `wr_addr`==`rd_addr`k, the register loads `wr_data`.
- All read ports are independent. Any number may share an address, including the write address.

## Timing
- Clear duration: `busy` is high during reset and for exactly `DEPTH` cycles after the first edge with `rst_n`=1. The first write can be accepted on cycle `DEPTH`+1 after reset release.
- `RD_REG`=0: a committed write is visible on `rd_data` immediately after the write edge. During the write cycle itself, the old data is shown.
- `RD_REG`=1: one-cycle latency from `rd_addr` to `rd_data`. A same-cycle write to the read address returns the new data after that edge.
- `wr_err` rises one cycle after the offending edge's inputs, i.e. it is visible after that edge.
- Reset mid-clear or mid-write: the edge with `rst_n`=0 commits no write. The sequencer restarts at address 0.
- `clr_cnt` never exceeds `DEPTH`-1; there is no wrap beyond `DEPTH`.

## Test plan
All tests use `DATA_W`=8, `ADDR_W`=4, `DEPTH`=12, `N_RD`=2, `CLR_VAL`=8'hA5. Run each with `RD_REG`=0 and `RD_REG`=1.
1. Release reset; count cycles → `busy` is high for exactly 12 cycles. Afterwards, reads of addresses 0..11 all return A5; a read of address 14 returns A5.
2. After clear, write 0x3C to address 5, then read 5 on port 0 and 4 on port 1 → port 0 = 3C and port 1 = A5. With `RD_REG`=1, port 0 shows 3C one cycle later.
3. With `RD_REG`=1, write 0x77 to address 9 while port 1 reads address 9 in the same cycle → port 1 = 77 after that edge; `wr_ack`=1.
4. Write to address 13 → `wr_ack`=0; `wr_err`=1 next cycle; addresses 0..11 unchanged. Then pulse `clr_req` → `wr_err`=0 and `busy` high for 12 cycles.
5. During a clear (cycle 4 of 12), write 0x11 to address 2 → `wr_ack`=0, `wr_err`=1, and address 2 reads A5 after the clear. A `clr_req` in the same window does not extend `busy` past 12 cycles.
6. In `IDLE`, assert `wr_en` (address 3, 0x42) and `clr_req` together → `wr_ack`=1, then the clear runs; address 3 reads A5. Assert `rst_n`=0 mid-clear → the sequencer restarts and `busy` lasts a full 12 cycles after release.

Source files
------------

// File: rtl/multi_port_ram.sv
// multi_port_ram: DEPTH x DATA_W LUT-style RAM with one synchronous write port and N_RD read
// ports (asynchronous or registered write-first), a clear sequencer that writes CLR_VAL to
// every word after reset and on request, out-of-range protection, and a sticky write error.
//
// Ports:
//   clk      sole clock, rising edge
//   rst_n    synchronous active-low reset
//   wr_en    write request
//   wr_addr  write address
//   wr_data  write data
//   clr_req  request a full clear (ignored while a clear is running)
//   rd_addr  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  packed read data, port k at [k*DATA_W +: DATA_W]
//   wr_ack   combinational, this cycle's write commits at the next edge
//   busy     registered, clear sequencer owns the array
//   wr_err   registered, sticky, a write was rejected; cleared when a clear starts
module multi_port_ram #(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       ADDR_W  = 8,
  parameter int unsigned       DEPTH   = 256,
  parameter int unsigned       N_RD    = 2,
  parameter int unsigned       RD_REG  = 0,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic                     wr_ack,
  output logic                     busy,
  output logic                     wr_err
);

  // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic {StClear, StIdle} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                busy_q;
  logic                wr_err_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_in_range;

  assign wr_in_range = {1'b0, wr_addr} < DepthExt;
  assign wr_ack      = wr_en & ~busy_q & wr_in_range;
  assign busy        = busy_q;
  assign wr_err      = wr_err_q;

  // Clear sequencer and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
      wr_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          // Any write during a clear is rejected; clr_req is ignored here.
          if (wr_en) wr_err_q <= 1'b1;
          if (clr_cnt_q == LastAddr) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
        StIdle: begin
          if (clr_req) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
            wr_err_q  <= 1'b0;
          end else if (wr_en && !wr_ack) begin
            wr_err_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= StClear;
          clr_cnt_q <= '0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset; the reset edge itself commits nothing.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == StClear) begin
        mem[clr_cnt_q] <= CLR_VAL;
      end else if (wr_ack) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] raw;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      raw = CLR_VAL;
      if (!busy_q && ({1'b0, addr} < DepthExt)) raw = mem[addr];
    end

    if (RD_REG != 0) begin : g_reg
      logic [DATA_W-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_q <= CLR_VAL;
        end else if (wr_ack && (wr_addr == addr)) begin
          rd_q <= wr_data;  // write-first bypass
        end else begin
          rd_q <= raw;
        end
      end
      assign rd_data[k*DATA_W +: DATA_W] = rd_q;
    end else begin : g_async
      assign rd_data[k*DATA_W +: DATA_W] = raw;
    end
  end

endmodule

// File: tb/tb_multi_port_ram.sv
// Self-checking bench for multi_port_ram. Two instances (asynchronous and registered read)
// share all inputs and are compared every cycle against a behavioural model.
module tb_multi_port_ram;

  localparam logic [7:0] Cv = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        clr_req;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data0, rd_data1;
  logic        ack0, ack1, busy0, busy1, err0, err1;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  bit         chk_en = 1'b0;
  bit         m_busy = 1'b1;
  int         m_rem  = 12;
  bit         m_err  = 1'b0;
  logic [7:0] m_mem [12];
  logic [7:0] m_rdq [2];

  always #5 clk = ~clk;

  multi_port_ram #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(12), .N_RD(2), .RD_REG(0), .CLR_VAL(8'hA5)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .rd_addr(rd_addr), .rd_data(rd_data0), .wr_ack(ack0),
    .busy(busy0), .wr_err(err0)
  );

  multi_port_ram #(
    .DATA_W(8), .ADDR_W(4), .DEPTH(12), .N_RD(2), .RD_REG(1), .CLR_VAL(8'hA5)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .rd_addr(rd_addr), .rd_data(rd_data1), .wr_ack(ack1),
    .busy(busy1), .wr_err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value a read of address a returns given current model contents.
  function automatic logic [7:0] raw(input logic [3:0] a);
    if (m_busy) return Cv;
    if (a < 4'd12) return m_mem[a];
    return Cv;
  endfunction

  function automatic logic exp_ack();
    return wr_en && !m_busy && (wr_addr < 4'd12);
  endfunction

  task automatic do_checks();
    check("ack_async", 32'(ack0), 32'(exp_ack()));
    check("ack_reg", 32'(ack1), 32'(exp_ack()));
    check("busy_async", 32'(busy0), 32'(m_busy));
    check("busy_reg", 32'(busy1), 32'(m_busy));
    check("err_async", 32'(err0), 32'(m_err));
    check("err_reg", 32'(err1), 32'(m_err));
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rd_async%0d", k), 32'(rd_data0[k*8 +: 8]), 32'(raw(rd_addr[k*4 +: 4])));
      check($sformatf("rd_reg%0d", k), 32'(rd_data1[k*8 +: 8]), 32'(m_rdq[k]));
    end
  endtask

  task automatic model_edge();
    logic a;
    a = exp_ack();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) m_rdq[k] = Cv;
      else if (a && wr_addr == rd_addr[k*4 +: 4]) m_rdq[k] = wr_data;
      else m_rdq[k] = raw(rd_addr[k*4 +: 4]);
    end
    if (!rst_n) begin
      m_busy = 1'b1;
      m_rem  = 12;
      m_err  = 1'b0;
    end else if (m_busy) begin
      if (wr_en) m_err = 1'b1;
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0;
        for (int i = 0; i < 12; i++) m_mem[i] = Cv;
      end
    end else begin
      if (a) m_mem[wr_addr] = wr_data;
      if (clr_req) begin
        m_busy = 1'b1;
        m_rem  = 12;
        m_err  = 1'b0;
      end else if (wr_en && !a) begin
        m_err = 1'b1;
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic step();
    #1;
    if (chk_en) do_checks();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy1 === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check(tag, 32'(n), 32'd12);
  endtask

  task automatic idle_inputs();
    wr_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 12; i++) m_mem[i] = Cv;
    m_rdq[0] = Cv;
    m_rdq[1] = Cv;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0; rd_addr = '0;
    @(negedge clk);
    step();
    chk_en = 1'b1;
    step();

    // 1: clear after reset release, then full readback plus out-of-range address
    rst_n = 1'b1;
    count_busy("busy_len_reset");
    for (int a = 0; a < 12; a++) begin
      rd_addr = {4'(11 - a), 4'(a)};
      step();
    end
    rd_addr = {4'd14, 4'd14};
    step();
    step();

    // 2: write 3C to 5, read 5 on port 0 and 4 on port 1
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h3C; rd_addr = {4'd4, 4'd5};
    step();
    idle_inputs();
    #1;
    check("async_new_data", 32'(rd_data0[7:0]), 32'h3C);
    check("reg_bypass_p0", 32'(rd_data1[7:0]), 32'h3C);
    check("p1_untouched", 32'(rd_data0[15:8]), 32'hA5);
    step();

    // 3: same-cycle write and read of address 9 on port 1
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h77; rd_addr = {4'd9, 4'd0};
    #1;
    check("ack_addr9", 32'(ack1), 32'd1);
    check("async_old_data", 32'(rd_data0[15:8]), 32'hA5);
    step();
    idle_inputs();
    #1;
    check("reg_wf_p1", 32'(rd_data1[15:8]), 32'h77);
    step();

    // 4: out-of-range write sets sticky error; clear request drops it
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 8'hEE;
    #1;
    check("ack_oor", 32'(ack0), 32'd0);
    step();
    idle_inputs();
    for (int a = 0; a < 12; a++) begin
      rd_addr = {4'd0, 4'(a)};
      step();
    end
    check("err_sticky", 32'(err0), 32'd1);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("err_cleared", 32'(err1), 32'd0);
    count_busy("busy_len_req");

    // 5: write and clr_req during a clear
    clr_req = 1'b1;
    step();
    begin
      int n;
      n = 0;
      while (busy1 === 1'b1 && n < 40) begin
        if (n == 3) begin
          wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h11; clr_req = 1'b1;
        end else begin
          idle_inputs();
        end
        n++;
        step();
      end
      check("busy_len_no_ext", 32'(n), 32'd12);
    end
    idle_inputs();
    check("err_in_clear", 32'(err0), 32'd1);
    rd_addr = {4'd2, 4'd2};
    step();
    step();

    // 6: write and clr_req together in IDLE, then reset mid-clear
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h42; clr_req = 1'b1; rd_addr = {4'd3, 4'd3};
    #1;
    check("ack_with_clr", 32'(ack0), 32'd1);
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    count_busy("busy_len_rst_mid");
    check("err_after_clr", 32'(err0), 32'd0);
    step();
    check("addr3_cleared", 32'(rd_data0[7:0]), 32'hA5);
    step();

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      clr_req = ($urandom_range(0, 39) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 8'($urandom);
      rd_addr = ($urandom_range(0, 3) == 0) ? {wr_addr, 4'($urandom)} : 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
